// File: rtl/muxes_pkg.sv
// Shared definitions for the L2 lane serializer: widths, lane count, idle symbol, fill rule.
// Build option: MUXES_IDLE_FILL_EN replaces invalid lane words with the idle/comma symbol.
package muxes_pkg;

  localparam int BW            = 9;
  localparam int LANES         = 4;
  localparam int SEL_W         = 2;
  localparam logic [7:0] IDLE_SYM = 8'hBC;

  typedef logic [BW-1:0] lane_word_t;

  // Valid words pass untouched; invalid ones become the configured filler.
  function automatic lane_word_t fill(input lane_word_t w);
    lane_word_t r;
    if (w[BW-1]) begin
      r = w;
    end else begin
`ifdef MUXES_IDLE_FILL_EN
      r = {1'b0, IDLE_SYM};
`else
      r = '0;
`endif
    end
    return r;
  endfunction

endpackage

// File: rtl/muxes_logic_l2_if.sv
// Lane-input / serialized-output bundle of the L2 serializer.
// master = lane source and stream sink, slave = the serializer itself.
interface muxes_logic_l2_if #(
  parameter int CNT_W = 8
) ();
  import muxes_pkg::*;

  lane_word_t        data0;
  lane_word_t        data1;
  lane_word_t        data2;
  lane_word_t        data3;
  logic              frame_ld;
  lane_word_t        outEtapaL2;
  logic              frame_start;
  logic [CNT_W-1:0]  inv_cnt;

  modport master (
    output data0, data1, data2, data3,
    input  frame_ld, outEtapaL2, frame_start, inv_cnt
  );

  modport slave (
    input  data0, data1, data2, data3,
    output frame_ld, outEtapaL2, frame_start, inv_cnt
  );

endinterface

// File: rtl/muxes_lane_sel.sv
// Free-running lane selector with frame decode; also usable by the demux side
// to stay aligned to the same 4-cycle frame.
module muxes_lane_sel
  import muxes_pkg::*;
(
  input  logic             clk4f,
  input  logic             reset_L,
  output logic [SEL_W-1:0] sel,
  output logic             frame_ld,
  output logic             frame_start
);

  always_ff @(posedge clk4f or negedge reset_L) begin
    if (!reset_L) begin
      sel         <= '0;
      frame_start <= 1'b0;
    end else begin
      sel         <= sel + 1'b1;
      frame_start <= (sel == '0);
    end
  end

  // Last slot of the frame: lanes are sampled on the coming edge.
  assign frame_ld = (sel == SEL_W'(LANES - 1));

endmodule

// File: rtl/muxes_logic_l2.sv
// 4:1 lane serializer: captures four lane words once per frame and replays them
// in lane order on one stream, with a frame marker and saturating invalid count.
module muxes_logic_l2
  import muxes_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic clk4f,
  input  logic reset_L,
  muxes_logic_l2_if.slave bus
);

  logic [SEL_W-1:0] sel;
  logic             frame_ld;
  logic             frame_start;
  lane_word_t       lane_in [LANES];
  lane_word_t       shadow  [LANES];
  lane_word_t       cur_word;
  lane_word_t       out_reg;
  logic [CNT_W-1:0] inv_cnt_reg;

  muxes_lane_sel u_lane_sel (
    .clk4f       (clk4f),
    .reset_L     (reset_L),
    .sel         (sel),
    .frame_ld    (frame_ld),
    .frame_start (frame_start)
  );

  assign lane_in[0] = bus.data0;
  assign lane_in[1] = bus.data1;
  assign lane_in[2] = bus.data2;
  assign lane_in[3] = bus.data3;

  // Lane 3 of the old frame is read on the same edge that loads the new one.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_shadow
      always_ff @(posedge clk4f or negedge reset_L) begin
        if (!reset_L) begin
          shadow[gi] <= '0;
        end else if (frame_ld) begin
          shadow[gi] <= lane_in[gi];
        end
      end
    end
  endgenerate

  assign cur_word = shadow[sel];

  always_ff @(posedge clk4f or negedge reset_L) begin
    if (!reset_L) begin
      out_reg     <= '0;
      inv_cnt_reg <= '0;
    end else begin
      out_reg <= fill(cur_word);
      if (!cur_word[BW-1] && (inv_cnt_reg != {CNT_W{1'b1}})) begin
        inv_cnt_reg <= inv_cnt_reg + 1'b1;
      end
    end
  end

  assign bus.frame_ld    = frame_ld;
  assign bus.frame_start = frame_start;
  assign bus.outEtapaL2  = out_reg;
  assign bus.inv_cnt     = inv_cnt_reg;

endmodule
